ram_arbiter: RTL and testbench

Time-slices the single-port main RAM between the video scanner, the 6502 core and one DMA requester (e.g. a disk or language-card peripheral) on the 14 MHz master clock. It generates the RAM strobes (ras_n, cas_n, ax), the phase0 half-cycle indicator and the CPU clock-enable. Each 14-tick CPU cycle is split into a 7-tick video half and a 7-tick CPU/DMA half. It sits between clock_generator/video_generator, cpu65xx and single_port_ram, and replaces the ad-hoc RAM muxing and latching in the top level.

---
 rtl/ram_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_ram_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Time-slices the single-port main RAM between the video scanner, the 6502
//   core and one DMA requester. Each 14-tick CPU cycle is a 7-tick video half
//   (t = 0..6) followed by a 7-tick CPU/DMA half (t = 7..13). Every 65th cycle
//   the video half can be stretched by two ticks. All outputs are registered.
//
// Ports
//   Clock_14Mhz, RESET_N              master clock, async active-low reset
//   cpu_addr/cpu_data_out/cpu_we      CPU access request (sampled at t = 7)
//   video_addr                        scanner fetch address (sampled at t = 0)
//   dma_req/dma_addr/dma_wdata/dma_we DMA request and access (sampled at t = 7)
//   dma_gnt, dma_done                 DMA-owned half indicator, end pulse
//   ram_addr/ram_data_in/ram_we/ram_q RAM port (ram_q has 1-tick latency)
//   ras_n, cas_n, ax, phase0          RAM strobes and half indicator
//   cpu_enable                        one-tick CPU clock enable at t = 13
//   mem_data_l, video_data_l, video_ld latched read data and video strobe
module ram_arbiter #(
  parameter int LONG_CYCLE_EN = 1,
  parameter int MAX_DMA_RUN   = 4
) (
  input  logic        Clock_14Mhz,
  input  logic        RESET_N,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_out,
  input  logic        cpu_we,
  input  logic [15:0] video_addr,
  input  logic        dma_req,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  input  logic        dma_we,
  output logic        dma_gnt,
  output logic        dma_done,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_data_in,
  output logic        ram_we,
  input  logic [7:0]  ram_q,
  output logic        ras_n,
  output logic        cas_n,
  output logic        ax,
  output logic        phase0,
  output logic        cpu_enable,
  output logic [7:0]  mem_data_l,
  output logic [7:0]  video_data_l,
  output logic        video_ld
);

  localparam int RUN_W = (MAX_DMA_RUN < 2) ? 1 : $clog2(MAX_DMA_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DMA_RUN);

  logic [3:0]       t_q, t_d;
  logic [1:0]       ext_q, ext_d;       // extra ticks spent at t = 6 in a long half
  logic [6:0]       c_q, c_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             own_dma_q, own_dma_d;
  logic             wr_q, wr_d;         // owner of the current half is writing
  logic [15:0]      ram_addr_q, ram_addr_d;
  logic [7:0]       ram_data_in_q, ram_data_in_d;
  logic [7:0]       mem_data_l_q, mem_data_l_d;
  logic [7:0]       video_data_l_q, video_data_l_d;
  logic             ram_we_q, ram_we_d;
  logic             ras_n_q, ras_n_d, cas_n_q, cas_n_d, ax_q, ax_d, phase0_q, phase0_d;
  logic             dma_gnt_q, dma_gnt_d, dma_done_q, dma_done_d;
  logic             cpu_enable_q, cpu_enable_d, video_ld_q, video_ld_d;

  logic             long_half, video_last, dma_pick;
  logic [3:0]       k_d;

  always_comb begin
    long_half  = (LONG_CYCLE_EN != 0) && (c_q == 7'd64);
    video_last = (t_q == 4'd6) && (!long_half || (ext_q == 2'd2));
    dma_pick   = dma_req && ((MAX_DMA_RUN == 0) || (run_q != RUN_MAX));

    // Tick / stretch / cycle counters
    if ((t_q == 4'd6) && !video_last) begin
      t_d   = 4'd6;
      ext_d = ext_q + 2'd1;
    end else begin
      t_d   = (t_q == 4'd13) ? 4'd0 : t_q + 4'd1;
      ext_d = 2'd0;
    end
    c_d = c_q;
    if (t_q == 4'd13) c_d = (c_q == 7'd64) ? 7'd0 : c_q + 7'd1;

    // Ownership of the coming CPU half is fixed on the last video tick
    own_dma_d = own_dma_q;
    run_d     = run_q;
    if (video_last) begin
      own_dma_d = dma_pick;
      run_d     = dma_pick ? run_q + 1'b1 : '0;
    end

    // Strobes are computed from the tick being entered so they are registered
    k_d      = (t_d >= 4'd7) ? t_d - 4'd7 : t_d;
    ras_n_d  = !((k_d >= 4'd1) && (k_d <= 4'd5));
    cas_n_d  = !((k_d >= 4'd3) && (k_d <= 4'd5));
    ax_d     = (k_d < 4'd3);
    phase0_d = (t_d >= 4'd7);

    ram_addr_d    = ram_addr_q;
    ram_data_in_d = ram_data_in_q;
    wr_d          = wr_q;
    if (t_q == 4'd13) begin
      ram_addr_d = video_addr;
      wr_d       = 1'b0;
    end else if (video_last) begin
      ram_addr_d    = dma_pick ? dma_addr  : cpu_addr;
      ram_data_in_d = dma_pick ? dma_wdata : cpu_data_out;
      wr_d          = dma_pick ? dma_we    : cpu_we;
    end

    ram_we_d     = (t_d == 4'd11) && wr_q;
    dma_gnt_d    = phase0_d && own_dma_d;
    cpu_enable_d = (t_d == 4'd13) && !own_dma_d;
    dma_done_d   = (t_d == 4'd13) && own_dma_d;
    // In a stretched half the strobe marks the final hold tick only
    video_ld_d   = (t_d == 4'd6) && (!long_half || (ext_d == 2'd2));

    video_data_l_d = video_data_l_q;
    if (t_q == 4'd5) video_data_l_d = ram_q;
    mem_data_l_d = mem_data_l_q;
    if (t_q == 4'd12) mem_data_l_d = wr_q ? ram_data_in_q : ram_q;
  end

  always_ff @(posedge Clock_14Mhz or negedge RESET_N) begin
    if (!RESET_N) begin
      t_q            <= 4'd0;
      ext_q          <= 2'd0;
      c_q            <= 7'd0;
      run_q          <= '0;
      own_dma_q      <= 1'b0;
      wr_q           <= 1'b0;
      ram_addr_q     <= 16'h0000;
      ram_data_in_q  <= 8'h00;
      mem_data_l_q   <= 8'h00;
      video_data_l_q <= 8'h00;
      ram_we_q       <= 1'b0;
      ras_n_q        <= 1'b1;
      cas_n_q        <= 1'b1;
      ax_q           <= 1'b1;
      phase0_q       <= 1'b0;
      dma_gnt_q      <= 1'b0;
      dma_done_q     <= 1'b0;
      cpu_enable_q   <= 1'b0;
      video_ld_q     <= 1'b0;
    end else begin
      t_q            <= t_d;
      ext_q          <= ext_d;
      c_q            <= c_d;
      run_q          <= run_d;
      own_dma_q      <= own_dma_d;
      wr_q           <= wr_d;
      ram_addr_q     <= ram_addr_d;
      ram_data_in_q  <= ram_data_in_d;
      mem_data_l_q   <= mem_data_l_d;
      video_data_l_q <= video_data_l_d;
      ram_we_q       <= ram_we_d;
      ras_n_q        <= ras_n_d;
      cas_n_q        <= cas_n_d;
      ax_q           <= ax_d;
      phase0_q       <= phase0_d;
      dma_gnt_q      <= dma_gnt_d;
      dma_done_q     <= dma_done_d;
      cpu_enable_q   <= cpu_enable_d;
      video_ld_q     <= video_ld_d;
    end
  end

  assign ram_addr     = ram_addr_q;
  assign ram_data_in  = ram_data_in_q;
  assign ram_we       = ram_we_q;
  assign ras_n        = ras_n_q;
  assign cas_n        = cas_n_q;
  assign ax           = ax_q;
  assign phase0       = phase0_q;
  assign dma_gnt      = dma_gnt_q;
  assign dma_done     = dma_done_q;
  assign cpu_enable   = cpu_enable_q;
  assign video_ld     = video_ld_q;
  assign mem_data_l   = mem_data_l_q;
  assign video_data_l = video_data_l_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: a main instance (long cycles on, DMA run limit 4)
// driven cycle by cycle, plus a second instance (no long cycles, unlimited
// DMA) sharing the same inputs. Expected events are queued as stimulus is
// issued; monitors pop and compare when the DUT strobes.
module tb_ram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] cpu_addr, video_addr, dma_addr;
  logic [7:0]  cpu_data_out, dma_wdata;
  logic        cpu_we, dma_req, dma_we;
  logic [7:0]  ram_q;

  logic        dma_gnt, dma_done, ram_we, ras_n, cas_n, ax, phase0, cpu_enable, video_ld;
  logic [15:0] ram_addr;
  logic [7:0]  ram_data_in, mem_data_l, video_data_l;

  logic        d0_dma_gnt, d0_dma_done, d0_ram_we, d0_ras_n, d0_cas_n, d0_ax, d0_phase0;
  logic        d0_cpu_enable, d0_video_ld;
  logic [15:0] d0_ram_addr;
  logic [7:0]  d0_ram_data_in, d0_mem_data_l, d0_video_data_l;

  ram_arbiter #(.LONG_CYCLE_EN(1), .MAX_DMA_RUN(4)) u_dut (
    .Clock_14Mhz(clk), .RESET_N(rst_n), .cpu_addr(cpu_addr), .cpu_data_out(cpu_data_out),
    .cpu_we(cpu_we), .video_addr(video_addr), .dma_req(dma_req), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_we(dma_we), .dma_gnt(dma_gnt), .dma_done(dma_done),
    .ram_addr(ram_addr), .ram_data_in(ram_data_in), .ram_we(ram_we), .ram_q(ram_q),
    .ras_n(ras_n), .cas_n(cas_n), .ax(ax), .phase0(phase0), .cpu_enable(cpu_enable),
    .mem_data_l(mem_data_l), .video_data_l(video_data_l), .video_ld(video_ld)
  );

  ram_arbiter #(.LONG_CYCLE_EN(0), .MAX_DMA_RUN(0)) u_dut0 (
    .Clock_14Mhz(clk), .RESET_N(rst_n), .cpu_addr(cpu_addr), .cpu_data_out(cpu_data_out),
    .cpu_we(cpu_we), .video_addr(video_addr), .dma_req(dma_req), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_we(dma_we), .dma_gnt(d0_dma_gnt), .dma_done(d0_dma_done),
    .ram_addr(d0_ram_addr), .ram_data_in(d0_ram_data_in), .ram_we(d0_ram_we), .ram_q(ram_q),
    .ras_n(d0_ras_n), .cas_n(d0_cas_n), .ax(d0_ax), .phase0(d0_phase0),
    .cpu_enable(d0_cpu_enable), .mem_data_l(d0_mem_data_l), .video_data_l(d0_video_data_l),
    .video_ld(d0_video_ld)
  );

  // Synchronous RAM model with one tick of read latency
  logic [7:0] mem [logic [15:0]];
  function automatic logic [7:0] rd(input logic [15:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction
  initial mem[16'h2000] = 8'h3C;
  always @(posedge clk) begin
    ram_q <= rd(ram_addr);
    if (ram_we) mem[ram_addr] = ram_data_in;
  end

  typedef struct { int kind; int tick; bit chk; logic [7:0] data; } ev_t;
  typedef struct { int tick; logic [15:0] addr; logic [7:0] data; } wr_t;
  ev_t evq[$];
  ev_t vq[$];
  wr_t wq[$];
  int  gq[$];

  int checks = 0;
  int errors = 0;
  int tick;
  bit gnt_prev;
  int gnt_len;
  bit d0_chk = 1'b0;
  int d0_win_cnt = 0;
  int d0_free_cnt = 0;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) tick <= 0;
    else        tick <= tick + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (tick %0d)", name, act, exp, tick);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: strobe at tick %0d, required none", name, tick);
  endtask

  function automatic int cstart(input int n);
    return 14 * n + 2 * (n / 65);
  endfunction

  function automatic bit is_long(input int n);
    return (n % 65) == 64;
  endfunction

  task automatic wait_tick(input int target);
    int b;
    b = 0;
    @(negedge clk);
    while (tick != target && b < 3000) begin
      @(negedge clk);
      b++;
    end
    if (tick != target) begin
      checks++;
      errors++;
      $display("FAIL wait_tick: tick %0d, required %0d", tick, target);
    end
  endtask

  // kind: 0 = CPU half, 1 = DMA half, 2 = no strobe expected (reset hits first)
  task automatic do_cycle(input int n, input logic [15:0] ca, input bit cwe, input logic [7:0] cd,
                          input logic [15:0] va, input bit dreq, input logic [15:0] da,
                          input bit dwe, input logic [7:0] dd, input int kind,
                          input bit dchk, input logic [7:0] dexp, input bit vchk,
                          input logic [7:0] vexp);
    if (n > 0) begin
      wait_tick(cstart(n) - 1);
      check("strobes_t13", {phase0, ras_n, cas_n, ax}, 4'b1110);
    end
    cpu_addr = ca; cpu_we = cwe; cpu_data_out = cd; video_addr = va;
    dma_req = dreq; dma_addr = da; dma_we = dwe; dma_wdata = dd;
    vq.push_back('{2, cstart(n) + 6 + (is_long(n) ? 2 : 0), vchk, vexp});
    if (kind != 2) evq.push_back('{kind, cstart(n + 1) - 1, dchk, dexp});
    if (kind == 1) gq.push_back(cstart(n) + 7);
    if (kind == 1 && dwe) wq.push_back('{cstart(n) + 11, da, dd});
    if (kind != 1 && cwe) wq.push_back('{cstart(n) + 11, ca, cd});
  endtask

  task automatic check_reset(input string name);
    check({name, "_strobes"}, {ras_n, cas_n, ax, phase0}, 4'b1110);
    check({name, "_pulses"}, {ram_we, cpu_enable, dma_gnt, dma_done, video_ld}, 5'b0);
    check({name, "_ram_port"}, {ram_addr, ram_data_in}, 24'h0);
    check({name, "_latches"}, {mem_data_l, video_data_l}, 16'h0);
    check({name, "_dut0"}, {d0_ras_n, d0_cas_n, d0_ax, d0_phase0, d0_ram_we, d0_cpu_enable,
                            d0_dma_gnt, d0_dma_done, d0_video_ld, d0_ram_addr, d0_ram_data_in,
                            d0_mem_data_l, d0_video_data_l}, {4'b1110, 5'b0, 40'h0});
  endtask

  // Monitor for the main instance
  always @(negedge clk) begin : mon
    ev_t e;
    wr_t w;
    if (!rst_n) begin
      gnt_prev = 1'b0;
    end else begin
      if (cpu_enable || dma_done) begin
        if (evq.size() == 0) unexpected("cpu_strobe");
        else begin
          e = evq.pop_front();
          check("strobe_kind", {cpu_enable, dma_done}, (e.kind == 1) ? 2'b01 : 2'b10);
          check("strobe_tick", tick, e.tick);
          if (e.chk) check("mem_data_l", mem_data_l, e.data);
        end
      end
      if (video_ld) begin
        if (vq.size() == 0) unexpected("video_ld");
        else begin
          e = vq.pop_front();
          check("video_ld_tick", tick, e.tick);
          if (e.chk) check("video_data_l", video_data_l, e.data);
        end
      end
      if (ram_we) begin
        if (wq.size() == 0) unexpected("ram_we");
        else begin
          w = wq.pop_front();
          check("ram_we_tick", tick, w.tick);
          check("ram_we_addr", ram_addr, w.addr);
          check("ram_we_data", ram_data_in, w.data);
        end
      end
      if (dma_gnt && !gnt_prev) begin
        if (gq.size() == 0) unexpected("dma_gnt");
        else check("gnt_start", tick, gq.pop_front());
        gnt_len = 1;
      end else if (dma_gnt) begin
        gnt_len++;
      end else if (gnt_prev) begin
        check("gnt_len", gnt_len, 7);
      end
      gnt_prev = dma_gnt;
    end
  end

  // Monitor for the no-long-cycle / unlimited-DMA instance
  always @(negedge clk) begin
    if (rst_n && d0_cpu_enable) begin
      if (tick >= 84 && tick <= 167) d0_win_cnt++;
      if (d0_chk && tick >= 182) begin
        d0_free_cnt++;
        check("dut0_spacing", tick % 14, 13);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    cpu_addr = 16'h0; cpu_we = 1'b0; cpu_data_out = 8'h0; video_addr = 16'h0;
    dma_req = 1'b0; dma_addr = 16'h0; dma_we = 1'b0; dma_wdata = 8'h0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset1");

    // Cycle 0: CPU write 0x0400 <- 0xA5 (mem_data_l follows the written value)
    do_cycle(0, 16'h0400, 1'b1, 8'hA5, 16'h1000, 1'b0, 16'h0, 1'b0, 8'h0, 0, 1'b1, 8'hA5, 1'b0, 8'h0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    // Cycle 1: read back, video fetch of 0x2000
    do_cycle(1, 16'h0400, 1'b0, 8'h0, 16'h2000, 1'b0, 16'h0, 1'b0, 8'h0, 0, 1'b1, 8'hA5, 1'b1, 8'h3C);
    // Cycle 2: DMA write 0x0300 <- 0x77
    do_cycle(2, 16'h0400, 1'b0, 8'h0, 16'h1000, 1'b1, 16'h0300, 1'b1, 8'h77, 1, 1'b1, 8'h77, 1'b0, 8'h0);
    do_cycle(3, 16'h0300, 1'b0, 8'h0, 16'h1000, 1'b0, 16'h0, 1'b0, 8'h0, 0, 1'b1, 8'h77, 1'b0, 8'h0);
    // Cycle 4: DMA read, request dropped mid-half
    do_cycle(4, 16'h0300, 1'b0, 8'h0, 16'h1000, 1'b1, 16'h0400, 1'b0, 8'h0, 1, 1'b1, 8'hA5, 1'b0, 8'h0);
    wait_tick(cstart(4) + 9);
    check("gnt_mid_half", dma_gnt, 1'b1);
    dma_req = 1'b0;
    do_cycle(5, 16'h0400, 1'b0, 8'h0, 16'h1000, 1'b0, 16'h0, 1'b0, 8'h0, 0, 1'b1, 8'hA5, 1'b0, 8'h0);
    // Cycles 6..11: request held, four DMA halves, one forced CPU half, DMA again
    for (int n = 6; n <= 9; n++)
      do_cycle(n, 16'h0400, 1'b0, 8'h0, 16'h1000, 1'b1, 16'h0300, 1'b0, 8'h0, 1, 1'b1, 8'h77, 1'b0, 8'h0);
    do_cycle(10, 16'h0400, 1'b0, 8'h0, 16'h1000, 1'b1, 16'h0300, 1'b0, 8'h0, 0, 1'b1, 8'hA5, 1'b0, 8'h0);
    do_cycle(11, 16'h0400, 1'b0, 8'h0, 16'h1000, 1'b1, 16'h0300, 1'b0, 8'h0, 1, 1'b1, 8'h77, 1'b0, 8'h0);
    do_cycle(12, 16'h0300, 1'b0, 8'h0, 16'h1000, 1'b0, 16'h0, 1'b0, 8'h0, 0, 1'b1, 8'h77, 1'b0, 8'h0);
    // Free run through the long cycle (c = 64)
    for (int n = 13; n <= 66; n++) begin
      do_cycle(n, 16'h0400, 1'b0, 8'h0, (n == 40) ? 16'h2000 : 16'h1000, 1'b0, 16'h0, 1'b0, 8'h0,
               0, 1'b1, 8'hA5, (n == 40), 8'h3C);
      if (n == 13) begin
        d0_chk = 1'b1;
        check("dut0_unlimited_dma", d0_win_cnt, 0);
      end
    end
    // Cycle 67: CPU write interrupted by reset at t = 11
    do_cycle(67, 16'h0500, 1'b1, 8'h5A, 16'h1000, 1'b0, 16'h0, 1'b0, 8'h0, 2, 1'b0, 8'h0, 1'b0, 8'h0);
    wait_tick(cstart(67) + 11);
    #2 rst_n = 1'b0;
    #1 check("ram_we_async_reset", ram_we, 1'b0);
    d0_chk = 1'b0;
    check("dut0_free_run_count", d0_free_cnt, 55);
    repeat (3) @(negedge clk);
    check_reset("reset2");
    do_cycle(0, 16'h0300, 1'b0, 8'h0, 16'h1000, 1'b0, 16'h0, 1'b0, 8'h0, 0, 1'b1, 8'h77, 1'b0, 8'h0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    do_cycle(1, 16'h0400, 1'b0, 8'h0, 16'h2000, 1'b0, 16'h0, 1'b0, 8'h0, 0, 1'b1, 8'hA5, 1'b1, 8'h3C);
    wait_tick(cstart(2) + 2);
    check("strobes_pending", evq.size(), 0);
    check("video_pending", vq.size(), 0);
    check("writes_pending", wq.size(), 0);
    check("grants_pending", gq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
